oled_i2c_seq: RTL and testbench
===============================

OLED_I2C_SEQ -- requirements
Module: oled_i2c_seq

Interface
REQ-001 SHALL have parameter DEPTH, default 16: command/data FIFO depth in entries, a power of 2 and at least 2.
REQ-002 SHALL have parameter DEV_ADDR, default 8'h78: 8-bit I2C address byte, write form.
REQ-003 SHALL have parameter MAX_BURST, default 32: maximum payload bytes per I2C transaction, at least 1.
REQ-004 SHALL have parameter RETRY_MAX, default 3: retries per transaction, used only with NACK_RETRY_EN.
REQ-005 SHALL have the following ports (name, direction, width, meaning):
- CLK  in  1  single clock; all logic on rising edge.
- ASYNC_RST_L  in  1  asynchronous, active-low reset.
- CMD_DAT  in  8  byte to enqueue.
- DC  in  1  0 = command, 1 = display data; enqueued with the byte.
- WR  in  1  push strobe.
- ERR_CLR  in  1  clears ERR.
- FULL  out  1  FIFO full.
- EMPTY  out  1  FIFO empty.
- BUSY  out  1  transaction in progress.
- ERR  out  1  sticky NACK error.
- M_BYTE  out  8  byte to the byte-level I2C master.
- M_VALID  out  1  byte request.
- M_FIRST  out  1  master issues START before M_BYTE.
- M_LAST  out  1  master issues STOP after M_BYTE.
- M_READY  in  1  master accepts the request.
- M_DONE  in  1  one-cycle pulse: byte completed.
- M_ACK  in  1  slave ACK; valid with M_DONE.

Function
REQ-006 SHALL store {DC, CMD_DAT} in the FIFO when WR=1 and FULL=0; WR while FULL=1 is ignored, including when a pop occurs in the same cycle.
REQ-007 SHALL derive FULL and EMPTY from a registered count of width log2(DEPTH)+1; pointers wrap modulo DEPTH.
REQ-008 SHALL implement states IDLE, ADDR, CTRL, DATA, each byte state having sub-phases REQ (M_VALID=1) and WAIT (M_VALID=0, awaiting M_DONE).
REQ-009 SHALL leave IDLE for ADDR:REQ on the first cycle EMPTY=0; the head entry's DC is latched as the transaction type.
REQ-010 ADDR SHALL drive M_BYTE=DEV_ADDR with M_FIRST=1.
REQ-011 CTRL SHALL drive M_BYTE=8'h00 for a command type and 8'h40 for a data type.
REQ-012 DATA SHALL drive M_BYTE from the FIFO head.
REQ-013 In every byte state, REQ SHALL hold M_VALID and M_BYTE stable until M_READY=1, then move to WAIT; M_DONE outside WAIT is ignored.
REQ-014 In DATA, M_LAST SHALL be 1 when any of these holds: burst count = MAX_BURST-1; FIFO count = 1; the next entry's DC differs from the latched type.
REQ-015 M_LAST SHALL be evaluated when entering DATA:REQ and held constant while M_VALID=1.
REQ-016 M_DONE with M_ACK=1 in DATA SHALL pop the head and increment the burst count; the next state is IDLE if M_LAST was set, else DATA:REQ.
REQ-017 M_DONE with M_ACK=1 in ADDR or CTRL SHALL advance to the next byte state.
REQ-018 M_DONE with M_ACK=0 in any state SHALL be handled per REQ-024/REQ-025; the master issues STOP on NACK itself.
REQ-019 Outputs SHALL be driven as follows:
- BUSY = (state != IDLE).
- Idle-to-ADDR latency: 1 cycle after EMPTY falls.
- Back-to-back transactions: one IDLE cycle between them.
REQ-020 ERR SHALL set on abort and clear on ERR_CLR=1; a simultaneous set takes priority.

Reset
REQ-021 ASYNC_RST_L=0 SHALL immediately force the following, mid-transaction included, with no STOP issued:
- State IDLE; FIFO empty.
- FULL=0, EMPTY=1, BUSY=0, ERR=0.
- M_VALID=0, M_FIRST=0, M_LAST=0, M_BYTE=0.
- Counters 0.
REQ-022 Deassertion SHALL take effect on the first rising CLK edge after ASYNC_RST_L rises.

Configuration
REQ-023 Macro NACK_RETRY_EN SHALL select the NACK handling.
REQ-024 With NACK_RETRY_EN defined, a NACK SHALL behave as follows:
- If the retry count < RETRY_MAX: increment it and restart at ADDR:REQ; already-popped bytes are not resent.
- Otherwise: abort.
- The retry count clears on IDLE entry.
REQ-025 Without NACK_RETRY_EN, a NACK SHALL abort immediately.
REQ-026 Abort SHALL flush the FIFO, set ERR and return to IDLE.

Verification
REQ-027 Case: push 3 commands 8'hAE, 8'hD5, 8'h80 (DC=0); master always ready/ACK. Required M_BYTE sequence: 78(FIRST), 00, AE, D5, 80(LAST); EMPTY=1; BUSY falls.
REQ-028 Case: push 2 data bytes, then 1 command. Required: two transactions, 78,40,d0,d1(LAST) then 78,00,c0(LAST).
REQ-029 Case: DEPTH=4, MAX_BURST=2; push 4 data bytes with M_READY held 0. Required: FULL=1, 5th WR ignored, then split into 2 transactions of 2 bytes.
REQ-030 Case: NACK on the address byte. Required with macro and RETRY_MAX=3: 3 retries then a 4th NACK aborts: ERR=1, EMPTY=1. Required without macro: immediate abort after the first NACK.
REQ-031 Case: assert ASYNC_RST_L=0 during DATA:WAIT. Required: outputs per REQ-021 with no clock edge; after release, a new push transmits normally.
REQ-032 Case: WR and pop in the same cycle at count 1 and at count DEPTH. Required: count unchanged at 1; at DEPTH, the push is dropped and count becomes DEPTH-1.

Source files
------------

// File: rtl/oled_i2c_seq.sv
// Command/data byte sequencer for an SSD1306-style OLED over a byte-level I2C master.
// Optional NACK retry is enabled by defining the macro NACK_RETRY_EN.
module oled_i2c_seq #(
  parameter int         DEPTH     = 16,
  parameter logic [7:0] DEV_ADDR  = 8'h78,
  parameter int         MAX_BURST = 32,
  parameter int         RETRY_MAX = 3
) (
  input  logic       CLK,
  input  logic       ASYNC_RST_L,
  input  logic [7:0] CMD_DAT,
  input  logic       DC,
  input  logic       WR,
  input  logic       ERR_CLR,
  output logic       FULL,
  output logic       EMPTY,
  output logic       BUSY,
  output logic       ERR,
  output logic [7:0] M_BYTE,
  output logic       M_VALID,
  output logic       M_FIRST,
  output logic       M_LAST,
  input  logic       M_READY,
  input  logic       M_DONE,
  input  logic       M_ACK
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam int BW = $clog2(MAX_BURST + 1);

  // Handshake: a byte request is offered while M_VALID=1 with M_BYTE/M_FIRST/M_LAST
  // stable; it is taken on the rising edge where M_READY=1. The master then reports
  // completion with a one-cycle M_DONE, M_ACK qualifying it.
  typedef enum logic [2:0] {
    S_IDLE, S_ADDR_REQ, S_ADDR_WAIT, S_CTRL_REQ, S_CTRL_WAIT, S_DATA_REQ, S_DATA_WAIT
  } state_t;

  state_t state, state_nx;

  logic [8:0]    mem [DEPTH];
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic [CW-1:0] count;
  logic [BW-1:0] burst;
  logic [8:0]    head;
  logic          next_dc;
  logic          type_q, last_q, last_held, err_q;
  logic          push, pop, abort, ack_done, last_now;

`ifdef NACK_RETRY_EN
  localparam int RW = (RETRY_MAX > 0) ? $clog2(RETRY_MAX + 1) : 1;
  logic [RW-1:0] retry_cnt;
  logic          retry;
`endif

  assign FULL     = (count == CW'(DEPTH));
  assign EMPTY    = (count == '0);
  assign BUSY     = (state != S_IDLE);
  assign ERR      = err_q;
  assign push     = WR && !FULL;
  assign ack_done = M_DONE && M_ACK;
  assign head     = mem[rd_ptr];
  assign next_dc  = mem[rd_ptr + AW'(1)][8];

  // A byte is the last of its burst if the burst is full, the FIFO runs dry,
  // or the following entry belongs to the other transaction type.
  assign last_now = (burst == BW'(MAX_BURST - 1)) || (count == CW'(1)) || (next_dc != type_q);

  always_ff @(posedge CLK) begin
    if (push) mem[wr_ptr] <= {DC, CMD_DAT};
  end

  always_ff @(posedge CLK or negedge ASYNC_RST_L) begin
    if (!ASYNC_RST_L) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else if (abort) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + AW'(1);
      if (pop)  rd_ptr <= rd_ptr + AW'(1);
      if (push && !pop)      count <= count + CW'(1);
      else if (pop && !push) count <= count - CW'(1);
    end
  end

  always_comb begin
    state_nx = state;
    pop      = 1'b0;
    abort    = 1'b0;
`ifdef NACK_RETRY_EN
    retry    = 1'b0;
`endif
    case (state)
      S_IDLE:      if (!EMPTY)   state_nx = S_ADDR_REQ;
      S_ADDR_REQ:  if (M_READY)  state_nx = S_ADDR_WAIT;
      S_ADDR_WAIT: if (ack_done) state_nx = S_CTRL_REQ;
      S_CTRL_REQ:  if (M_READY)  state_nx = S_CTRL_WAIT;
      S_CTRL_WAIT: if (ack_done) state_nx = S_DATA_REQ;
      S_DATA_REQ:  if (M_READY)  state_nx = S_DATA_WAIT;
      S_DATA_WAIT: begin
        if (ack_done) begin
          pop      = 1'b1;
          state_nx = last_q ? S_IDLE : S_DATA_REQ;
        end
      end
      default:     state_nx = S_IDLE;
    endcase
    // The master has already sent STOP on a NACK; only the recovery path is chosen here.
    if (M_DONE && !M_ACK &&
        (state == S_ADDR_WAIT || state == S_CTRL_WAIT || state == S_DATA_WAIT)) begin
`ifdef NACK_RETRY_EN
      if (retry_cnt < RW'(RETRY_MAX)) begin
        retry    = 1'b1;
        state_nx = S_ADDR_REQ;
      end else begin
        abort    = 1'b1;
        state_nx = S_IDLE;
      end
`else
      abort    = 1'b1;
      state_nx = S_IDLE;
`endif
    end
  end

  always_comb begin
    M_VALID = 1'b0;
    M_FIRST = 1'b0;
    M_LAST  = 1'b0;
    M_BYTE  = '0;
    case (state)
      S_ADDR_REQ: begin
        M_VALID = 1'b1;
        M_FIRST = 1'b1;
        M_BYTE  = DEV_ADDR;
      end
      S_CTRL_REQ: begin
        M_VALID = 1'b1;
        M_BYTE  = type_q ? 8'h40 : 8'h00;
      end
      S_DATA_REQ: begin
        M_VALID = 1'b1;
        M_BYTE  = head[7:0];
        // Sampled on the first REQ cycle, then frozen so late pushes cannot flip it.
        M_LAST  = last_held ? last_q : last_now;
      end
      default: ;
    endcase
  end

  always_ff @(posedge CLK or negedge ASYNC_RST_L) begin
    if (!ASYNC_RST_L) begin
      state     <= S_IDLE;
      type_q    <= 1'b0;
      last_q    <= 1'b0;
      last_held <= 1'b0;
      burst     <= '0;
      err_q     <= 1'b0;
    end else begin
      state     <= state_nx;
      last_held <= (state == S_DATA_REQ) && (state_nx == S_DATA_REQ);
      if (state == S_IDLE && !EMPTY) type_q <= head[8];
      if (state == S_DATA_REQ)       last_q <= M_LAST;
      if (state_nx == S_ADDR_REQ && state != S_ADDR_REQ) burst <= '0;
      else if (pop)                                      burst <= burst + BW'(1);
      if (abort)        err_q <= 1'b1;
      else if (ERR_CLR) err_q <= 1'b0;
    end
  end

`ifdef NACK_RETRY_EN
  always_ff @(posedge CLK or negedge ASYNC_RST_L) begin
    if (!ASYNC_RST_L)                             retry_cnt <= '0;
    else if (state_nx == S_IDLE && state != S_IDLE) retry_cnt <= '0;
    else if (retry)                               retry_cnt <= retry_cnt + RW'(1);
  end
`endif

endmodule

// File: tb/tb_oled_i2c_seq.sv
// Bench for oled_i2c_seq: two instances (default sizing and DEPTH=4/MAX_BURST=2),
// a byte-level master responder per instance and a transaction-level expected model.
module tb_oled_i2c_seq;

`ifdef NACK_RETRY_EN
  localparam int NACKS = 4;
`else
  localparam int NACKS = 1;
`endif
  localparam int LIM = 3000;

  // clock / reset
  logic clk = 1'b0;
  always #5 clk = ~clk;
  logic rst_n;

  logic [7:0] cmd_dat [2];
  logic       dc [2], wr [2], err_clr [2];
  logic       full [2], empty [2], busy [2], err [2];
  logic [7:0] m_byte [2];
  logic       m_valid [2], m_first [2], m_last [2];
  logic       m_ready [2], m_done [2], m_ack [2];

  int  total = 0;
  int  bad   = 0;
  bit  rdy_en [2];
  int  nack_left [2];
  int  done_cnt [2];
  int  mb [2] = '{32, 2};

  // scoreboard: expected byte requests {first, last, byte}
  logic [9:0] exp_q[$];
  logic [9:0] exp_qb[$];
  logic [8:0] pend[$];

  oled_i2c_seq dut_a (
    .CLK(clk), .ASYNC_RST_L(rst_n), .CMD_DAT(cmd_dat[0]), .DC(dc[0]), .WR(wr[0]),
    .ERR_CLR(err_clr[0]), .FULL(full[0]), .EMPTY(empty[0]), .BUSY(busy[0]), .ERR(err[0]),
    .M_BYTE(m_byte[0]), .M_VALID(m_valid[0]), .M_FIRST(m_first[0]), .M_LAST(m_last[0]),
    .M_READY(m_ready[0]), .M_DONE(m_done[0]), .M_ACK(m_ack[0])
  );

  oled_i2c_seq #(.DEPTH(4), .MAX_BURST(2)) dut_b (
    .CLK(clk), .ASYNC_RST_L(rst_n), .CMD_DAT(cmd_dat[1]), .DC(dc[1]), .WR(wr[1]),
    .ERR_CLR(err_clr[1]), .FULL(full[1]), .EMPTY(empty[1]), .BUSY(busy[1]), .ERR(err[1]),
    .M_BYTE(m_byte[1]), .M_VALID(m_valid[1]), .M_FIRST(m_first[1]), .M_LAST(m_last[1]),
    .M_READY(m_ready[1]), .M_DONE(m_done[1]), .M_ACK(m_ack[1])
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s got=%0h required=%0h", name, act, req);
    end
  endtask

  function automatic int qsize(input int i);
    return (i == 0) ? exp_q.size() : exp_qb.size();
  endfunction

  task automatic exp_push(input int i, input logic [9:0] e);
    if (i == 0) exp_q.push_back(e);
    else        exp_qb.push_back(e);
  endtask

  // Model: group queued entries into transactions (type change or MAX_BURST splits them).
  task automatic model_emit(input int i);
    int   run;
    logic lst;
    run = 0;
    for (int k = 0; k < pend.size(); k++) begin
      if (run == 0) begin
        exp_push(i, {2'b10, 8'h78});
        exp_push(i, {2'b00, (pend[k][8] ? 8'h40 : 8'h00)});
      end
      run++;
      lst = (k == pend.size() - 1) || (run == mb[i]) || (pend[k+1][8] != pend[k][8]);
      if (lst) run = 0;
      exp_push(i, {1'b0, lst, pend[k][7:0]});
    end
    pend.delete();
  endtask

  // driver tasks
  task automatic push(input int i, input logic d, input logic [7:0] b, input bit modeled);
    wr[i] = 1'b1;
    dc[i] = d;
    cmd_dat[i] = b;
    if (modeled) pend.push_back({d, b});
    @(posedge clk); #1;
    wr[i] = 1'b0;
  endtask

  task automatic wait_idle(input int i, input string name);
    int n;
    n = 0;
    while (n < LIM && !(qsize(i) == 0 && !busy[i])) begin
      @(posedge clk); #2;
      n++;
    end
    total++;
    if (n >= LIM) begin
      bad++;
      $display("FAIL %s_timeout pending=%0d required=0", name, qsize(i));
    end
  endtask

  task automatic wait_done(input int i, input int target, input string name);
    int n;
    n = 0;
    while (n < LIM && done_cnt[i] < target) begin
      @(posedge clk); #2;
      n++;
    end
    check({name, "_done_wait"}, done_cnt[i], target);
  endtask

  task automatic chk_reset(input int i, input string tag);
    check({tag, "_full"},  full[i],    1'b0);
    check({tag, "_empty"}, empty[i],   1'b1);
    check({tag, "_busy"},  busy[i],    1'b0);
    check({tag, "_err"},   err[i],     1'b0);
    check({tag, "_req"},   {m_valid[i], m_first[i], m_last[i], m_byte[i]}, 11'h0);
  endtask

  // Master responder and per-cycle compare: checks every accepted request against
  // the scoreboard and that an offered request stays stable until taken.
  task automatic respond(input int i);
    int         wait_cnt;
    bit         prev_v;
    logic [9:0] prev, got;
    wait_cnt = 0;
    prev_v = 1'b0;
    prev = '0;
    forever begin
      @(posedge clk); #1;
      m_ready[i] = 1'b0;
      m_done[i]  = 1'b0;
      m_ack[i]   = 1'b0;
      got = {m_first[i], m_last[i], m_byte[i]};
      if (!rst_n) begin
        wait_cnt = 0;
        prev_v = 1'b0;
      end else begin
        if (m_valid[i]) check($sformatf("busy_with_valid%0d", i), busy[i], 1'b1);
        if (m_valid[i] && prev_v) check($sformatf("req_stable%0d", i), got, prev);
        prev_v = 1'b0;
        if (wait_cnt > 0) begin
          wait_cnt--;
          if (wait_cnt == 0) begin
            m_done[i] = 1'b1;
            m_ack[i]  = (nack_left[i] == 0);
            if (nack_left[i] > 0) nack_left[i]--;
            done_cnt[i]++;
          end
        end else if (m_valid[i] && rdy_en[i]) begin
          m_ready[i] = 1'b1;
          wait_cnt = 2;
          if (qsize(i) == 0) begin
            total++;
            bad++;
            $display("FAIL unexpected_req%0d got=%0h required=none", i, got);
          end else if (i == 0) check("req0", got, exp_q.pop_front());
          else                 check("req1", got, exp_qb.pop_front());
        end else if (m_valid[i]) begin
          prev_v = 1'b1;
          prev = got;
        end
      end
    end
  endtask

  initial respond(0);
  initial respond(1);

  initial begin
    #500000;
    $display("FAIL watchdog got=timeout required=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [9:0] lit [5];
    lit = '{10'h278, 10'h000, 10'h0AE, 10'h0D5, 10'h180};
    rst_n = 1'b0;
    for (int i = 0; i < 2; i++) begin
      cmd_dat[i] = '0; dc[i] = 1'b0; wr[i] = 1'b0; err_clr[i] = 1'b0;
      rdy_en[i] = 1'b0; nack_left[i] = 0; done_cnt[i] = 0;
    end
    repeat (3) @(posedge clk);
    #2;
    chk_reset(0, "rst_a");
    chk_reset(1, "rst_b");
    @(posedge clk); #3;
    rst_n = 1'b1;
    @(posedge clk); #1;

    // three commands in one transaction
    push(0, 1'b0, 8'hAE, 1'b1);
    push(0, 1'b0, 8'hD5, 1'b1);
    push(0, 1'b0, 8'h80, 1'b1);
    model_emit(0);
    check("model_len", exp_q.size(), 5);
    for (int k = 0; k < 5; k++) check($sformatf("model_cmd%0d", k), exp_q[k], lit[k]);
    check("addr_pending", {busy[0], m_valid[0], m_first[0], m_byte[0]}, {3'b111, 8'h78});
    rdy_en[0] = 1'b1;
    wait_idle(0, "cmds");
    check("cmds_empty", empty[0], 1'b1);

    // data then command: two transactions
    rdy_en[0] = 1'b0;
    push(0, 1'b1, 8'h11, 1'b1);
    push(0, 1'b1, 8'h22, 1'b1);
    push(0, 1'b0, 8'hA5, 1'b1);
    model_emit(0);
    check("model_mix_d1", exp_q[3], 10'h122);
    check("model_mix_c0", exp_q[6], 10'h1A5);
    rdy_en[0] = 1'b1;
    wait_idle(0, "mix");
    check("mix_empty", empty[0], 1'b1);

    // small FIFO fills, 5th write dropped, split into bursts of two
    for (int k = 0; k < 4; k++) push(1, 1'b1, 8'hB0 + 8'(k), 1'b1);
    check("b_full", full[1], 1'b1);
    push(1, 1'b1, 8'hEE, 1'b0);
    check("b_full_after_drop", full[1], 1'b1);
    model_emit(1);
    check("model_burst_len", exp_qb.size(), 8);
    check("model_burst_b1", exp_qb[3], 10'h1B1);
    rdy_en[1] = 1'b1;
    wait_idle(1, "burst");
    check("burst_empty", empty[1], 1'b1);

    // push coinciding with pop at count 1
    done_cnt[1] = 0;
    push(1, 1'b1, 8'h31, 1'b1);
    model_emit(1);
    wait_done(1, 3, "cnt1");
    wr[1] = 1'b1; dc[1] = 1'b1; cmd_dat[1] = 8'h32;
    pend.push_back({1'b1, 8'h32});
    model_emit(1);
    @(posedge clk); #2;
    wr[1] = 1'b0;
    check("cnt1_not_empty", empty[1], 1'b0);
    check("cnt1_not_full", full[1], 1'b0);
    wait_idle(1, "cnt1");
    check("cnt1_drained", empty[1], 1'b1);

    // push coinciding with pop at count DEPTH: push dropped
    rdy_en[1] = 1'b0;
    for (int k = 0; k < 4; k++) push(1, 1'b1, 8'h41 + 8'(k), 1'b1);
    check("cntd_full", full[1], 1'b1);
    model_emit(1);
    done_cnt[1] = 0;
    rdy_en[1] = 1'b1;
    wait_done(1, 3, "cntd");
    wr[1] = 1'b1; dc[1] = 1'b1; cmd_dat[1] = 8'h55;
    @(posedge clk); #2;
    wr[1] = 1'b0;
    check("cntd_full_after", full[1], 1'b0);
    check("cntd_not_empty", empty[1], 1'b0);
    wait_idle(1, "cntd");
    check("cntd_drained", empty[1], 1'b1);

    // asynchronous reset while a data byte is outstanding
    rdy_en[0] = 1'b0;
    push(0, 1'b1, 8'h61, 1'b1);
    push(0, 1'b1, 8'h62, 1'b1);
    push(0, 1'b1, 8'h63, 1'b1);
    model_emit(0);
    rdy_en[0] = 1'b1;
    begin
      int n;
      n = 0;
      while (n < LIM && exp_q.size() > 2) begin
        @(posedge clk); #2;
        n++;
      end
      check("rst_reach_data", exp_q.size(), 2);
    end
    @(posedge clk); #3;
    check("in_data_wait", {busy[0], m_valid[0]}, 2'b10);
    rst_n = 1'b0;
    #1;
    chk_reset(0, "midrst_a");
    exp_q.delete();
    @(posedge clk);
    @(posedge clk); #3;
    rst_n = 1'b1;
    @(posedge clk); #1;
    push(0, 1'b0, 8'hAF, 1'b1);
    model_emit(0);
    wait_idle(0, "after_rst");
    check("after_rst_empty", empty[0], 1'b1);

    // NACK on the address byte
    rdy_en[0] = 1'b0;
    nack_left[0] = NACKS;
    push(0, 1'b0, 8'hAE, 1'b0);
    push(0, 1'b0, 8'hAF, 1'b0);
    for (int k = 0; k < NACKS; k++) exp_push(0, 10'h278);
    rdy_en[0] = 1'b1;
    wait_idle(0, "nack");
    check("nack_all_used", nack_left[0], 0);
    check("nack_err", err[0], 1'b1);
    check("nack_flushed", empty[0], 1'b1);
    err_clr[0] = 1'b1;
    @(posedge clk); #1;
    err_clr[0] = 1'b0;
    check("err_cleared", err[0], 1'b0);

    repeat (5) @(posedge clk);
    #2;
    check("final_q_a", exp_q.size(), 0);
    check("final_q_b", exp_qb.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
